// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle on operand magnitudes, sign and special-case fixup in a final cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; captures operands, funct3 and rd_in
// CALC   | 32 iterations, counter 0..31
// FIX    | sign correction, divide special cases, result registered
// DONE   | done/reg_wr pulse for one cycle
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic            reg_wr,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   logic [1:0]        state;
   logic [4:0]        count;
   logic [2:0]        f3_q;
   logic              neg_a_q;
   logic              neg_b_q;
   logic [XLEN-1:0]   op_a_q;
   logic [XLEN-1:0]   op_b_q;
   logic [XLEN-1:0]   opnd_q;
   logic [2*XLEN-1:0] acc;

   logic              signed_a;
   logic              signed_b;
   logic              neg_a_in;
   logic              neg_b_in;
   logic [XLEN-1:0]   mag_a_in;
   logic [XLEN-1:0]   mag_b_in;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_trial;
   logic [2*XLEN-1:0] acc_next;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   fix_result;

   // Only MULHU/DIVU/REMU treat op_a as unsigned; op_b is also unsigned for MULHSU.
   always_comb begin
      signed_a = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
      signed_b = signed_a && (funct3 != 3'd2);
      neg_a_in = signed_a & op_a[XLEN-1];
      neg_b_in = signed_b & op_b[XLEN-1];
      mag_a_in = neg_a_in ? (~op_a + 1'b1) : op_a;
      mag_b_in = neg_b_in ? (~op_b + 1'b1) : op_b;
   end

   // Multiply: acc = {partial, multiplier}, shifting right each step.
   // Divide:   acc = {remainder, dividend/quotient}, shifting left each step.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
      div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
      if (f3_q[2]) begin
         if (div_trial[XLEN])
            acc_next = {acc[2*XLEN-2:0], 1'b0};
         else
            acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc[XLEN-1:1]};
      end
   end

   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? (~acc + 1'b1) : acc;
      quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      rem_fix  = neg_a_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
      div_zero = (op_b_q == '0);
      div_ovf  = !f3_q[0] && (op_a_q == MOST_NEG) && (op_b_q == ALL_ONES);
      fix_result = '0;
      case (f3_q)
         3'd0:    fix_result = prod_fix[XLEN-1:0];
         3'd1,
         3'd2,
         3'd3:    fix_result = prod_fix[2*XLEN-1:XLEN];
         3'd4,
         3'd5: begin
            if (div_zero)     fix_result = ALL_ONES;
            else if (div_ovf) fix_result = MOST_NEG;
            else              fix_result = quo_fix;
         end
         default: begin
            if (div_zero)     fix_result = op_a_q;
            else if (div_ovf) fix_result = '0;
            else              fix_result = rem_fix;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         count   <= '0;
         f3_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         opnd_q  <= '0;
         acc     <= '0;
         result  <= '0;
         rd_out  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_CALC;
                  count   <= '0;
                  f3_q    <= funct3;
                  neg_a_q <= neg_a_in;
                  neg_b_q <= neg_b_in;
                  op_a_q  <= op_a;
                  op_b_q  <= op_b;
                  rd_out  <= rd_in;
                  if (funct3[2]) begin
                     opnd_q <= mag_b_in;
                     acc    <= {{XLEN{1'b0}}, mag_a_in};
                  end else begin
                     opnd_q <= mag_a_in;
                     acc    <= {{XLEN{1'b0}}, mag_b_in};
                  end
               end
            end
            S_CALC: begin
               acc   <= acc_next;
               count <= count + 5'd1;
               if (count == 5'd31)
                  state <= S_FIX;
            end
            S_FIX: begin
               result <= fix_result;
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state == S_CALC) || (state == S_FIX);
      done   = (state == S_DONE);
      reg_wr = done;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It consumes the two source operands read from the register file (rs1/rs2 data) and returns a 32-bit result, destination index and one-cycle write strobe for the register-file write port. Every operation has a fixed 33-cycle latency. The core stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; accepted only in IDLE.
- `funct3`  in  3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  32: rs1 data (multiplicand / dividend).
- `op_b`  in  32: rs2 data (multiplier / divisor).
- `rd_in`  in  5: destination register index.
- `busy`  out  1: high in CALC and FIX.
- `done`  out  1: one-cycle pulse; `result` and `rd_out` valid.
- `reg_wr`  out  1: equal to `done`; drives register-file write enable.
- `result`  out  32: held until the next `done`.
- `rd_out`  out  5: captured `rd_in`, held until next accept.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE: on `start`=1, capture `funct3`, `rd_in`, operand magnitudes and sign flags; counter=0; go to CALC.
  - CALC: one iteration per edge; counter 0..31; after the iteration at counter=31, go to FIX.
  - FIX: apply sign correction and special cases, register `result`, go to DONE.
  - DONE: `done`=`reg_wr`=1 for exactly one cycle, then IDLE unconditionally.
- `start` is ignored in CALC, FIX and DONE. There is no queueing; the core must hold the request until `busy` is low.
- Signedness per operand:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply:
  - Unsigned shift-add on magnitudes into a 64-bit accumulator.
  - Negate the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; MULH* return bits [63:32].
- Divide:
  - Restoring radix-2 division on magnitudes, producing a 32-bit quotient and a 32-bit remainder.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - Rounding is toward zero.
- Special cases override the datapath in FIX; latency is unchanged.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op_a`.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- All arithmetic is modulo 2^32 / 2^64. Negating 0x80000000 yields 0x80000000.

## Timing
- Accept edge E0 (IDLE, `start`=1). Iterations happen on E1..E32. FIX happens on E33.
- `done`, `reg_wr` and the new `result` are visible in the cycle after E33, and `done` drops after E34.
- `busy` rises after E0 and falls after E33. A new `start` is accepted at the earliest on E35.
- The register file samples `reg_wr`/`rd_out`/`result` on the falling edge inside the `done` cycle. `rd_out`=0 is passed through; the register file ignores writes to x0.
- Reset values: state IDLE, `busy`=0, `done`=0, `reg_wr`=0, `result`=0, `rd_out`=0, counter=0.
- Reset asserted mid-operation aborts the operation. No `done` is produced, and the outputs show reset values after the reset edge.
- `reset` and `start` high on the same edge: reset wins.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), `rd_in`=5 -> `done` 33 cycles after accept, `result`=0xFFFFFFEB, `rd_out`=5, `reg_wr` high for 1 cycle.
- Upper-half products of 0xFFFFFFFF × 0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHU -> 0xFFFFFFFE
  - MULHSU -> 0xFFFFFFFF
- Divide −7 / 2 (0xFFFFFFF9, 0x00000002):
  - DIV -> 0xFFFFFFFD
  - REM -> 0xFFFFFFFF
  - DIVU -> 0x7FFFFFFC
  - REMU -> 0x00000001
- Special cases:
  - DIV 0x12345678 / 0 -> 0xFFFFFFFF
  - REMU 0x12345678 / 0 -> 0x12345678
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000
  - REM 0x80000000 / 0xFFFFFFFF -> 0
- `start` pulsed again at cycles 5 and 33 after accept -> both ignored; exactly one `done`; `busy` low from the `done` cycle; back-to-back `start` accepted on E35.
- `reset` asserted 10 cycles into a DIV -> no `done`; all outputs 0; a subsequent MULHU 0x10000 × 0x10000 returns 0x00000001.
